// File: rtl/debug_frame_rx.sv
// 8N1 UART receiver for the debug access path: recovers bytes from rxd and
// packs FRAME_BYTES of them, first byte in the MSBs, into one access word.
module debug_frame_rx #(
  parameter int CLKS_PER_BIT = 286,
  parameter int FRAME_BYTES  = 7,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rxd,
  output logic                     byte_valid,
  output logic [7:0]               byte_data,
  output logic [8*FRAME_BYTES-1:0] access_bits,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     timeout,
  output logic                     busy
);

  localparam int CW        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam int BCW       = $clog2(FRAME_BYTES + 1);
  localparam int AW        = 8 * FRAME_BYTES;

  localparam logic [CW-1:0]  HALF_BIT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]  FULL_BIT  = CW'(CLKS_PER_BIT);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

  state_t         r_state, w_state_next;
  logic           r_rxd_meta, r_rxs, r_rxs_d;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic [AW-1:0]  r_asm;
  logic [BCW-1:0] r_byte_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic           r_byte_valid, r_frame_valid, r_frame_err, r_timeout;
  logic [7:0]     r_byte_data;
  logic [AW-1:0]  r_access;

  logic          w_fall, w_expire, w_start_rx, w_bit_sample, w_stop_good, w_stop_bad;
  logic          w_to_run, w_to_hit;
  logic [AW-1:0] w_asm_next;

  // Synchroniser flops idle high so reset never manufactures a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_d    <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxs      <= r_rxd_meta;
      r_rxs_d    <= r_rxs;
    end
  end

  assign w_fall     = r_rxs_d & ~r_rxs;
  assign w_expire   = (r_cnt == CW'(1));
  assign w_asm_next = {r_asm[AW-9:0], r_shift};

  always_comb begin
    w_state_next = r_state;
    w_start_rx   = 1'b0;
    w_bit_sample = 1'b0;
    w_stop_good  = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_start_rx   = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_expire) w_state_next = r_rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_expire) begin
          w_bit_sample = 1'b1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_expire) begin
          w_stop_good  = r_rxs;
          w_stop_bad   = ~r_rxs;
          w_state_next = r_rxs ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (r_rxs) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A start edge in IDLE suppresses the timeout even on the expiry cycle.
  assign w_to_run = (r_state == S_IDLE) && (r_byte_cnt != '0) && !w_fall;
  assign w_to_hit = w_to_run && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_asm         <= '0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout     <= 1'b0;
      r_byte_data   <= '0;
      r_access      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_byte_valid  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout     <= 1'b0;

      if (w_start_rx)
        r_cnt <= HALF_BIT;
      else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP)
        r_cnt <= w_expire ? FULL_BIT : r_cnt - CW'(1);

      if (r_state == S_START) r_bit_idx <= '0;
      if (w_bit_sample) begin
        r_shift   <= {r_rxs, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_start_rx) begin
        r_to_cnt <= '0;
      end else if (w_to_hit) begin
        r_to_cnt   <= '0;
        r_byte_cnt <= '0;
        r_timeout  <= 1'b1;
      end else if (w_to_run) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end

      if (w_stop_good) begin
        r_byte_valid <= 1'b1;
        r_byte_data  <= r_shift;
        r_asm        <= w_asm_next;
        r_to_cnt     <= '0;
        if (r_byte_cnt == LAST_BYTE) begin
          r_byte_cnt    <= '0;
          r_access      <= w_asm_next;
          r_frame_valid <= 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + BCW'(1);
        end
      end

      if (w_stop_bad) begin
        r_frame_err <= 1'b1;
        r_byte_cnt  <= '0;
      end
    end
  end

  assign byte_valid  = r_byte_valid;
  assign byte_data   = r_byte_data;
  assign access_bits = r_access;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign timeout     = r_timeout;
  assign busy        = (r_state != S_IDLE) || (r_byte_cnt != '0);

endmodule

// File: tb/tb_debug_frame_rx.sv
// Directed bench for debug_frame_rx at 16 clocks per bit: frames, back-to-back
// timing, timeout, framing error, glitch rejection and mid-frame reset.
module tb_debug_frame_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rxd = 1'b1;
  logic        byte_valid, frame_valid, frame_err, timeout, busy;
  logic [7:0]  byte_data;
  logic [55:0] access_bits;

  int checks = 0;
  int failures = 0;
  int n_bv = 0, n_fv = 0, n_fe = 0, n_to = 0, n_fv_alone = 0;
  longint cyc = 0, fv_last = 0, fv_prev = 0;

  debug_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .FRAME_BYTES(7),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .access_bits(access_bits),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (byte_valid) n_bv <= n_bv + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (timeout) n_to <= n_to + 1;
    if (frame_valid) begin
      n_fv    <= n_fv + 1;
      fv_prev <= fv_last;
      fv_last <= cyc;
      if (!byte_valid) n_fv_alone <= n_fv_alone + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int idle_bits);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_cycles(CPB);
    end
    rxd = 1'b1;
    wait_cycles(CPB);
    wait_cycles(idle_bits * CPB);
  endtask

  task automatic send_frame(input logic [55:0] w, input int idle_bits);
    for (int b = 0; b < 7; b++) send_byte(w[55-8*b -: 8], idle_bits);
  endtask

  int bv0, fv0, fe0, to0;
  longint gap;
  logic [55:0] frame_a, frame_b, frame_c;

  initial begin
    frame_a = 56'h0123456789ABCD;
    frame_b = 56'h11223344556677;
    frame_c = 56'hDEADBEEFC0FFEE;

    wait_cycles(4);
    chk("reset_byte_valid", byte_valid, 0);
    chk("reset_frame_valid", frame_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_byte_data", byte_data, 0);
    chk("reset_access_bits", access_bits, 0);
    reset = 1'b0;
    wait_cycles(4 * CPB);

    // Single frame with one idle bit between bytes.
    bv0 = n_bv; fv0 = n_fv;
    send_frame(frame_a, 1);
    chk("t1_byte_pulses", n_bv - bv0, 7);
    chk("t1_frame_pulses", n_fv - fv0, 1);
    chk("t1_access_bits", access_bits, frame_a);
    chk("t1_byte_data", byte_data, 8'hCD);
    chk("t1_busy_idle", busy, 0);

    // Two back-to-back frames, zero idle time.
    fv0 = n_fv;
    send_frame(frame_a, 0);
    send_frame(56'hFFFFFFFFFFFFFF, 0);
    wait_cycles(2 * CPB);
    gap = fv_last - fv_prev;
    chk("t2_frame_pulses", n_fv - fv0, 2);
    chk("t2_frame_gap", gap, 70 * CPB);
    chk("t2_access_bits", access_bits, 56'hFFFFFFFFFFFFFF);
    chk("t2_fv_with_bv", n_fv_alone, 0);

    // Inter-byte timeout after three bytes.
    to0 = n_to; fv0 = n_fv;
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    chk("t3_busy_partial", busy, 1);
    wait_cycles(300);
    chk("t3_no_early_timeout", n_to - to0, 0);
    wait_cycles(40);
    chk("t3_timeout_pulse", n_to - to0, 1);
    chk("t3_access_unchanged", access_bits, 56'hFFFFFFFFFFFFFF);
    chk("t3_busy_after_timeout", busy, 0);
    send_frame(frame_b, 1);
    chk("t3_frame_after_timeout", access_bits, frame_b);
    chk("t3_frame_pulses", n_fv - fv0, 1);

    // Framing error after two good bytes, stop held low for 40 cycles.
    bv0 = n_bv; fe0 = n_fe; fv0 = n_fv;
    send_byte(8'h5A, 0);
    send_byte(8'h3C, 0);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = (i % 2 == 0);
      wait_cycles(CPB);
    end
    rxd = 1'b0;
    wait_cycles(40);
    rxd = 1'b1;
    wait_cycles(2 * CPB);
    chk("t4_one_frame_err", n_fe - fe0, 1);
    chk("t4_only_good_bytes", n_bv - bv0, 2);
    chk("t4_byte_data_kept", byte_data, 8'h3C);
    chk("t4_count_cleared", busy, 0);
    send_frame(frame_c, 1);
    chk("t4_frame_after_err", access_bits, frame_c);
    chk("t4_frame_pulses", n_fv - fv0, 1);

    // Short glitch: false start, no pulses.
    bv0 = n_bv; fv0 = n_fv; fe0 = n_fe; to0 = n_to;
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(1);
    chk("t5_busy_during_start", busy, 1);
    wait_cycles(7);
    chk("t5_busy_cleared", busy, 0);
    wait_cycles(10 * CPB);
    chk("t5_no_pulses", (n_bv - bv0) + (n_fv - fv0) + (n_fe - fe0) + (n_to - to0), 0);

    // Reset during byte 4, data bit 3 (data 0x0F keeps the line high there).
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'b1;
      wait_cycles(CPB);
    end
    wait_cycles(CPB / 2);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    chk("t6_byte_data_zero", byte_data, 0);
    chk("t6_access_zero", access_bits, 0);
    chk("t6_busy_zero", busy, 0);
    chk("t6_pulses_zero", {byte_valid, frame_valid, frame_err, timeout}, 0);
    wait_cycles(2 * CPB);
    fv0 = n_fv;
    send_frame(frame_a, 0);
    wait_cycles(CPB);
    chk("t6_frame_after_reset", access_bits, frame_a);
    chk("t6_frame_pulses", n_fv - fv0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
